// File: rtl/ntt_masked_combine_div2_pipe.sv
// Masked INTT back end: per-lane share recombine, mod-PRIME reduce, optional div2, framed valid/ready output.
// Optional sticky range check on share sums is built when NTT_COMBINE_RANGE_CHK_EN is defined.
module ntt_masked_combine_div2_pipe #(
    parameter int unsigned WIDTH          = 46,
    parameter int unsigned HALF_WIDTH     = WIDTH / 2,
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned NUM_SHARES     = 2,
    parameter int unsigned PRIME          = 8380417,
    parameter int unsigned BEATS_PER_POLY = 64,
    parameter int unsigned MODE_W         = 2,
    parameter logic [MODE_W-1:0] PWM_MODE = MODE_W'(2)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  zeroize,
    input  logic [MODE_W-1:0]                     mode,
    input  logic                                  div2_en,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_LANES*NUM_SHARES*WIDTH-1:0] shares_i,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NUM_LANES*HALF_WIDTH-1:0]       coeff_o,
    output logic [NUM_LANES*NUM_SHARES*WIDTH-1:0] shares_o,
    output logic                                  out_last,
    output logic                                  range_err_o
);

    localparam int unsigned SHARE_BITS = NUM_LANES * NUM_SHARES * WIDTH;
    localparam int unsigned CNT_W      = (BEATS_PER_POLY > 1) ? $clog2(BEATS_PER_POLY) : 1;
`ifdef NTT_COMBINE_RANGE_CHK_EN
    localparam int unsigned SUM_W      = WIDTH;
`else
    localparam int unsigned SUM_W      = HALF_WIDTH;
`endif
    localparam logic [HALF_WIDTH-1:0] PRIME_H   = HALF_WIDTH'(PRIME);
    localparam logic [HALF_WIDTH:0]   PRIME_W   = (HALF_WIDTH + 1)'(PRIME);
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS_PER_POLY - 1);

    logic                                  advance;
    logic [NUM_LANES-1:0][SUM_W-1:0]       sum_c;
    logic [NUM_LANES-1:0][HALF_WIDTH-1:0]  coeff_c;

    logic                                  s1_valid;
    logic                                  s1_pwm;
    logic                                  s1_div2;
    logic [NUM_LANES-1:0][HALF_WIDTH-1:0]  s1_sum;
    logic [SHARE_BITS-1:0]                 s1_shares;
    logic [CNT_W-1:0]                      beat_cnt;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign out_last = out_valid && (beat_cnt == LAST_BEAT);

    // Share word for [lane l][share s] sits at bit offset (l*NUM_SHARES + s)*WIDTH.
    always_comb begin
        sum_c = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int s = 0; s < NUM_SHARES; s++) begin
                sum_c[l] = sum_c[l] + shares_i[(l*NUM_SHARES + s)*WIDTH +: SUM_W];
            end
        end
    end

    // Single conditional subtract, then x/2 mod PRIME via (x + PRIME*odd) >> 1.
    always_comb begin
        logic [HALF_WIDTH-1:0] red;
        logic [HALF_WIDTH:0]   wide;
        red     = '0;
        wide    = '0;
        coeff_c = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            red  = (s1_sum[l] >= PRIME_H) ? (s1_sum[l] - PRIME_H) : s1_sum[l];
            wide = {1'b0, red} + (red[0] ? PRIME_W : '0);
            if (s1_pwm) begin
                coeff_c[l] = '0;
            end else if (s1_div2) begin
                coeff_c[l] = HALF_WIDTH'(wide >> 1);
            end else begin
                coeff_c[l] = red;
            end
        end
    end

`ifdef NTT_COMBINE_RANGE_CHK_EN
    logic [NUM_LANES-1:0] over_c;
    logic [NUM_LANES-1:0] s1_over;

    always_comb begin
        over_c = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            over_c[l] = (sum_c[l] >= SUM_W'(2 * PRIME));
        end
    end

    // Sticky flag; data path is untouched by an out-of-contract sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_over     <= '0;
            range_err_o <= 1'b0;
        end else if (zeroize) begin
            s1_over     <= '0;
            range_err_o <= 1'b0;
        end else begin
            if (advance && in_valid) begin
                s1_over <= over_c;
            end
            if (s1_valid && (|s1_over)) begin
                range_err_o <= 1'b1;
            end
        end
    end
`else
    assign range_err_o = 1'b0;
`endif

    // Both stages move together on advance; zeroize discards everything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_pwm    <= 1'b0;
            s1_div2   <= 1'b0;
            s1_sum    <= '0;
            s1_shares <= '0;
            out_valid <= 1'b0;
            coeff_o   <= '0;
            shares_o  <= '0;
            beat_cnt  <= '0;
        end else if (zeroize) begin
            s1_valid  <= 1'b0;
            s1_pwm    <= 1'b0;
            s1_div2   <= 1'b0;
            s1_sum    <= '0;
            s1_shares <= '0;
            out_valid <= 1'b0;
            coeff_o   <= '0;
            shares_o  <= '0;
            beat_cnt  <= '0;
        end else begin
            if (advance) begin
                s1_valid  <= in_valid;
                out_valid <= s1_valid;
                if (in_valid) begin
                    s1_pwm    <= (mode == PWM_MODE);
                    s1_div2   <= div2_en;
                    s1_shares <= shares_i;
                    for (int l = 0; l < NUM_LANES; l++) begin
                        s1_sum[l] <= HALF_WIDTH'(sum_c[l]);
                    end
                end
                if (s1_valid) begin
                    coeff_o  <= coeff_c;
                    shares_o <= s1_shares;
                end
            end
            if (out_valid && out_ready) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ntt_masked_combine_div2_pipe.sv
// Directed bench for ntt_masked_combine_div2_pipe: vector table, framing stream, stall/zeroize and range sequences.
module tb_ntt_masked_combine_div2_pipe;

    localparam int unsigned W  = 46;
    localparam int unsigned HW = 23;
    localparam int unsigned NL = 4;
    localparam int unsigned NS = 2;

    typedef struct packed {
        logic [NL-1:0][NS-1:0][W-1:0] sh;
        logic                         div2;
        logic                         pwm;
        logic [NL-1:0][HW-1:0]        exp;
    } vec_t;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         zeroize;
    logic [1:0]                   mode;
    logic                         div2_en;
    logic                         in_valid;
    logic                         in_ready;
    logic [NL-1:0][NS-1:0][W-1:0] shares_i;
    logic                         out_valid;
    logic                         out_ready;
    logic [NL-1:0][HW-1:0]        coeff_o;
    logic [NL-1:0][NS-1:0][W-1:0] shares_o;
    logic                         out_last;
    logic                         range_err_o;

    int ntests = 0;
    int nfail  = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    ntt_masked_combine_div2_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .zeroize    (zeroize),
        .mode       (mode),
        .div2_en    (div2_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shares_i   (shares_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .coeff_o    (coeff_o),
        .shares_o   (shares_o),
        .out_last   (out_last),
        .range_err_o(range_err_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_lane(input int v, input int l, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [HW-1:0] e);
        vecs[v].sh[l][0] = a;
        vecs[v].sh[l][1] = b;
        vecs[v].exp[l]   = e;
    endtask

    // Streams n beats (lane0 share0 = base+i), checking order and framing; out_ready toggles if asked.
    task automatic run_stream(input int n, input bit toggle, input int base, input int last_idx);
        int tx = 0;
        int rx = 0;
        int cyc = 0;
        while (rx < n && cyc < 1000) begin
            @(negedge clk);
            out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            #1;
            if (out_valid && out_ready) begin
                chk($sformatf("stream_data[%0d]", rx), 64'(coeff_o[0]), 64'(base + rx));
                chk($sformatf("stream_last[%0d]", rx), 64'(out_last), 64'(rx == last_idx));
                rx++;
            end
            in_valid = (tx < n);
            mode     = 2'd1;
            div2_en  = 1'b0;
            shares_i = '0;
            shares_i[0][0] = W'(base + tx);
            if (in_valid && in_ready) tx++;
            cyc++;
        end
        chk("stream_complete", 64'(rx), 64'(n));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        zeroize   = 1'b0;
        mode      = 2'd1;
        div2_en   = 1'b0;
        in_valid  = 1'b0;
        shares_i  = '0;
        out_ready = 1'b1;

        vecs[0] = '0;
        vecs[0].div2 = 1'b1;
        set_lane(0, 0, 46'd3, 46'd0, 23'd4190210);
        set_lane(0, 1, 46'd2, 46'd2, 23'd2);
        set_lane(0, 2, 46'd8380417, 46'd5, 23'd4190211);
        set_lane(0, 3, 46'd0, 46'd0, 23'd0);
        vecs[1] = vecs[0];
        vecs[1].div2 = 1'b0;
        vecs[1].exp = {23'd0, 23'd5, 23'd4, 23'd3};
        vecs[2] = '0;
        vecs[2].div2 = 1'b1;
        set_lane(2, 0, 46'd8380416, 46'd0, 23'd4190208);
        set_lane(2, 1, 46'd8380416, 46'd1, 23'd0);
        set_lane(2, 2, 46'd1, 46'd0, 23'd4190209);
        set_lane(2, 3, 46'h3FFF_FFFF_FFFF, 46'd2, 23'd4190209);
        vecs[3] = '0;
        set_lane(3, 0, 46'd8380418, 46'd0, 23'd1);
        set_lane(3, 1, 46'd4000000, 46'd4380416, 23'd8380416);
        set_lane(3, 2, 46'd8388607, 46'd0, 23'd8190);
        set_lane(3, 3, 46'd100, 46'd200, 23'd300);
        vecs[4] = '0;
        vecs[4].pwm = 1'b1;
        vecs[4].div2 = 1'b1;
        set_lane(4, 0, 46'h123456789AB, 46'h5, 23'd0);
        set_lane(4, 1, 46'd7, 46'd9, 23'd0);
        set_lane(4, 2, 46'h2AAA_AAAA_AAAA, 46'h1555_5555_5555, 23'd0);
        set_lane(4, 3, 46'd8380417, 46'd1, 23'd0);
        vecs[5] = '0;
        vecs[5].div2 = 1'b1;
        set_lane(5, 0, 46'd5, 46'd6, 23'd4190214);
        set_lane(5, 1, 46'd10, 46'd10, 23'd10);
        set_lane(5, 2, 46'd8380417, 46'd0, 23'd0);
        set_lane(5, 3, 46'd4190208, 46'd4190208, 23'd4190208);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_coeff", 64'(coeff_o[0] | coeff_o[1] | coeff_o[2] | coeff_o[3]), 64'd0);
        chk("rst_shares_o", 64'(|shares_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_range_err", 64'(range_err_o), 64'd0);

        for (int v = 0; v < 6; v++) begin
            shares_i = vecs[v].sh;
            mode     = vecs[v].pwm ? 2'd2 : 2'd1;
            div2_en  = vecs[v].div2;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_latency", v), 64'(out_valid), 64'd0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", v), 64'(out_valid), 64'd1);
            for (int l = 0; l < NL; l++) begin
                chk($sformatf("vec%0d_coeff%0d", v, l), 64'(coeff_o[l]), 64'(vecs[v].exp[l]));
                for (int s = 0; s < NS; s++)
                    chk($sformatf("vec%0d_shares%0d_%0d", v, l, s), 64'(shares_o[l][s]), 64'(vecs[v].sh[l][s]));
            end
        end

        // Fresh frame, then 65 beats with out_ready toggling: wrap lands beat 64 in a new frame.
        @(negedge clk);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        run_stream(65, 1'b1, 1000, 63);

        // Two beats in flight under stall (frame counter at 1), then zeroize.
        out_ready = 1'b0;
        shares_i = '0;
        shares_i[0][0] = W'(111);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        shares_i[0][0] = W'(222);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_coeff", 64'(coeff_o[0]), 64'd111);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("stall_hold_coeff", 64'(coeff_o[0]), 64'd111);
        chk("stall_hold_last", 64'(out_last), 64'd0);
        zeroize = 1'b1;
        @(posedge clk);
        @(negedge clk);
        zeroize = 1'b0;
        chk("zero_out_valid", 64'(out_valid), 64'd0);
        chk("zero_coeff", 64'(coeff_o[0]), 64'd0);
        chk("zero_shares_o", 64'(|shares_o), 64'd0);
        chk("zero_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("zero_dropped_beat", 64'(out_valid), 64'd0);
        run_stream(64, 1'b0, 2000, 63);

`ifdef NTT_COMBINE_RANGE_CHK_EN
        shares_i = '0;
        shares_i[1][0] = W'(16760834);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        shares_i = '0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("range_set", 64'(range_err_o), 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("range_sticky", 64'(range_err_o), 64'd1);
        zeroize = 1'b1;
        @(posedge clk);
        @(negedge clk);
        zeroize = 1'b0;
        chk("range_cleared", 64'(range_err_o), 64'd0);
`else
        shares_i = '0;
        shares_i[1][0] = W'(16760834);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("range_off", 64'(range_err_o), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
